rb_ctx_ctrl: RTL and testbench
==============================

// Module: rb_ctx_ctrl
// PURPOSE
//  Owns the single access port of the 16-entry register bank (8 user regs 0-7,
//  8 hidden regs 8-15). Passes CPU accesses straight through when idle. On
//  command it runs a multi-cycle context operation: SAVE user->hidden,
//  RESTORE hidden->user, or CLEAR user. The CPU is stalled while an operation
//  runs. Sits between the control unit / datapath and the register bank.
// PARAMETERS
//  NREG  8   registers per bank (user = 0..NREG-1, hidden = NREG..2*NREG-1)
//  DW    16  data width
//  AW    4   register select width (one field of rs; rs = 3*AW bits)
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     reset, asynchronous, active-low
//  cpu_rw_in    in   1     CPU write enable
//  cpu_rs_in    in   3*AW  CPU selects {wr[11:8], a[7:4], b[3:0]}
//  cpu_d_in     in   DW    CPU write data
//  cpu_stall_out out 1     1 = CPU access ignored this cycle, hold it
//  cmd_valid_in in   1     context command request
//  cmd_op_in    in   2     00 SAVE, 01 RESTORE, 10 CLEAR, 11 NOP
//  cmd_ready_out out 1     1 = command accepted when cmd_valid_in=1
//  done_out     out  1     one-cycle pulse, operation complete
//  rb_rw_out    out  1     register bank write enable
//  rb_rs_out    out  3*AW  register bank selects
//  rb_d_out     out  DW    register bank write data
//  rb_a_in      in   DW    register bank a read port (combinational)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, idx=0, op=NOP, done_out=0.
//   Outputs during reset follow the IDLE rules.
//  FSM states: IDLE, RUN.
//  IDLE:
//   - rb_rw_out/rb_rs_out/rb_d_out = cpu_* (pure combinational pass-through).
//   - cpu_stall_out=0, cmd_ready_out=1.
//   - Command handshake: cmd_valid_in & cmd_ready_out.
//     - On handshake, latch op and idx=0.
//     - The same-cycle CPU access still completes (CPU owns that cycle).
//     - Next state: RUN, or stays IDLE with done_out=1 next cycle for NOP.
//  RUN (one register per cycle, idx = 0..NREG-1):
//   - cpu_stall_out=1, cmd_ready_out=0. CPU inputs are ignored (no write).
//   - SAVE: rs={NREG+idx, idx, idx}, rw=1, d=rb_a_in.
//   - RESTORE: rs={idx, NREG+idx, NREG+idx}, rw=1, d=rb_a_in.
//   - CLEAR: rs={idx, 0, 0}, rw=1, d=0.
//   - Each write is read-then-write within one cycle (a port is combinational,
//     write lands on the rising edge).
//   - idx increments each cycle. At idx=NREG-1, the next state is IDLE and the
//     done_out register is set.
//  done_out: high exactly 1 cycle, the first IDLE cycle after the last write.
//   For NOP, it is high the cycle after the handshake.
//  Latency: handshake at cycle T; writes occur in T+1..T+NREG; done_out and
//   the CPU are released at T+NREG+1.
//  cmd_valid_in during RUN: not accepted. The requester holds it, and it is
//   accepted in the first IDLE cycle (back-to-back commands allowed).
//  Reset mid-RUN: abort immediately to IDLE. Partial copy is not resumed, and
//   no done_out is issued.
//  Widths: idx is AW bits. NREG+idx is computed in AW bits with no overflow
//   (2*NREG <= 2**AW).
// TESTING
//  1) Idle pass-through: cpu_rw=1, rs=0x300, d=0xBEEF -> rb_rw=1,
//     rb_rs=0x300, rb_d=0xBEEF, stall=0.
//  2) SAVE: user regs r0..r7 = 0x1000+i, op=00 -> hidden 8..15 = 0x1000+i;
//     stall high 8 cycles; done 1 cycle at T+9.
//  3) RESTORE after CPU overwrites r0..r7 with 0 -> r0..r7 = 0x1000+i again.
//     CPU writes issued during RUN have no effect.
//  4) CLEAR: r0..r7 -> 0; hidden regs unchanged; done at T+9. NOP: done at
//     T+1, stall never high.
//  5) Back-to-back: cmd_valid held across SAVE -> second command accepted in
//     the done cycle; no gap or overlap of writes.
//  6) rst_n low at RUN idx=3 -> immediate IDLE, stall=0, done_out never pulses.

Source files
------------

// File: rtl/rb_ctx_ctrl.sv
// Register bank context controller: passes CPU accesses to the bank when idle and
// runs one-register-per-cycle SAVE / RESTORE / CLEAR sequences while stalling the CPU.
module rb_ctx_ctrl #(
   parameter int NREG = 8,
   parameter int DW   = 16,
   parameter int AW   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_rw_in,
   input  logic [3*AW-1:0]   cpu_rs_in,
   input  logic [DW-1:0]     cpu_d_in,
   output logic              cpu_stall_out,
   input  logic              cmd_valid_in,
   input  logic [1:0]        cmd_op_in,
   output logic              cmd_ready_out,
   output logic              done_out,
   output logic              rb_rw_out,
   output logic [3*AW-1:0]   rb_rs_out,
   output logic [DW-1:0]     rb_d_out,
   input  logic [DW-1:0]     rb_a_in
);

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

   typedef enum logic [1:0] {
      OP_SAVE    = 2'b00,
      OP_RESTORE = 2'b01,
      OP_CLEAR   = 2'b10,
      OP_NOP     = 2'b11
   } op_e;

   localparam logic [AW-1:0] IDX_LAST = AW'(NREG - 1);
   localparam logic [AW-1:0] HID_BASE = AW'(NREG);

   state_e        state, state_next;
   op_e           op, op_next;
   logic [AW-1:0] idx, idx_next;
   logic          done_next;
   logic [AW-1:0] hid_idx;

   assign hid_idx = HID_BASE + idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         op       <= OP_NOP;
         idx      <= '0;
         done_out <= 1'b0;
      end else begin
         state    <= state_next;
         op       <= op_next;
         idx      <= idx_next;
         done_out <= done_next;
      end
   end

   // Handshake in IDLE latches the op; NOP completes without entering RUN.
   always_comb begin
      state_next = state;
      op_next    = op;
      idx_next   = idx;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid_in) begin
               op_next  = op_e'(cmd_op_in);
               idx_next = '0;
               if (op_e'(cmd_op_in) == OP_NOP) begin
                  done_next = 1'b1;
               end else begin
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            if (idx == IDX_LAST) begin
               state_next = IDLE;
               idx_next   = '0;
               done_next  = 1'b1;
            end else begin
               idx_next = idx + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The a port reads the source register combinationally, so each copy is a
   // read-then-write within a single cycle.
   always_comb begin
      cpu_stall_out = 1'b0;
      cmd_ready_out = 1'b1;
      rb_rw_out     = cpu_rw_in;
      rb_rs_out     = cpu_rs_in;
      rb_d_out      = cpu_d_in;
      if (state == RUN) begin
         cpu_stall_out = 1'b1;
         cmd_ready_out = 1'b0;
         rb_rw_out     = 1'b1;
         case (op)
            OP_SAVE: begin
               rb_rs_out = {hid_idx, idx, idx};
               rb_d_out  = rb_a_in;
            end
            OP_RESTORE: begin
               rb_rs_out = {idx, hid_idx, hid_idx};
               rb_d_out  = rb_a_in;
            end
            OP_CLEAR: begin
               rb_rs_out = {idx, {AW{1'b0}}, {AW{1'b0}}};
               rb_d_out  = '0;
            end
            default: begin
               rb_rw_out = 1'b0;
               rb_rs_out = '0;
               rb_d_out  = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rb_ctx_ctrl.sv
// Directed bench for rb_ctx_ctrl with a behavioural 16-entry register bank
// attached to its access port.
module tb_rb_ctx_ctrl;

   logic        clk;
   logic        rst_n;
   logic        cpu_rw_in;
   logic [11:0] cpu_rs_in;
   logic [15:0] cpu_d_in;
   logic        cpu_stall_out;
   logic        cmd_valid_in;
   logic [1:0]  cmd_op_in;
   logic        cmd_ready_out;
   logic        done_out;
   logic        rb_rw_out;
   logic [11:0] rb_rs_out;
   logic [15:0] rb_d_out;
   logic [15:0] rb_a_in;

   logic [15:0] bank [16];

   int checks = 0;
   int fails  = 0;
   int done_seen;

   rb_ctx_ctrl #(.NREG(8), .DW(16), .AW(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cpu_rw_in     (cpu_rw_in),
      .cpu_rs_in     (cpu_rs_in),
      .cpu_d_in      (cpu_d_in),
      .cpu_stall_out (cpu_stall_out),
      .cmd_valid_in  (cmd_valid_in),
      .cmd_op_in     (cmd_op_in),
      .cmd_ready_out (cmd_ready_out),
      .done_out      (done_out),
      .rb_rw_out     (rb_rw_out),
      .rb_rs_out     (rb_rs_out),
      .rb_d_out      (rb_d_out),
      .rb_a_in       (rb_a_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rb_rw_out) bank[rb_rs_out[11:8]] <= rb_d_out;
   end
   assign rb_a_in = bank[rb_rs_out[7:4]];

   task automatic applyStimulus(input logic rw, input logic [11:0] rs, input logic [15:0] d,
                                input logic valid, input logic [1:0] op);
      @(negedge clk);
      cpu_rw_in    = rw;
      cpu_rs_in    = rs;
      cpu_d_in     = d;
      cmd_valid_in = valid;
      cmd_op_in    = op;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Eight RUN cycles with a CPU write attempted every cycle, then the done cycle.
   task automatic runBody(input logic [1:0] op, input logic hold);
      logic [11:0] exp_rs;
      logic [15:0] exp_d;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, {4'(k), 8'h00}, 16'hDEAD, hold, op);
         #1;
         case (op)
            2'b00:   exp_rs = {4'(8 + k), 4'(k), 4'(k)};
            2'b01:   exp_rs = {4'(k), 4'(8 + k), 4'(8 + k)};
            default: exp_rs = {4'(k), 8'h00};
         endcase
         exp_d = (op == 2'b10) ? 16'h0000 : 16'(16'h1000 + k);
         checkOutput("run_stall", 32'(cpu_stall_out), 32'd1);
         checkOutput("run_ready", 32'(cmd_ready_out), 32'd0);
         checkOutput("run_done", 32'(done_out), 32'd0);
         checkOutput("run_rw", 32'(rb_rw_out), 32'd1);
         checkOutput("run_rs", 32'(rb_rs_out), 32'(exp_rs));
         checkOutput("run_d", 32'(rb_d_out), 32'(exp_d));
      end
      applyStimulus(1'b0, 12'h000, 16'h0000, hold, op);
      #1;
      checkOutput("done_pulse", 32'(done_out), 32'd1);
      checkOutput("done_stall", 32'(cpu_stall_out), 32'd0);
      checkOutput("done_ready", 32'(cmd_ready_out), 32'd1);
   endtask

   task automatic runOp(input logic [1:0] op, input logic hold);
      applyStimulus(1'b0, 12'h000, 16'h0000, 1'b1, op);
      #1;
      checkOutput("hs_ready", 32'(cmd_ready_out), 32'd1);
      checkOutput("hs_stall", 32'(cpu_stall_out), 32'd0);
      runBody(op, hold);
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 12'h000, 16'h0000, 1'b0, 2'b11);
   endtask

   initial begin
      rst_n        = 1'b0;
      cpu_rw_in    = 1'b0;
      cpu_rs_in    = '0;
      cpu_d_in     = '0;
      cmd_valid_in = 1'b0;
      cmd_op_in    = 2'b11;
      $display("[TB] reset");
      repeat (2) @(negedge clk);
      checkOutput("rst_done", 32'(done_out), 32'd0);
      checkOutput("rst_stall", 32'(cpu_stall_out), 32'd0);
      checkOutput("rst_ready", 32'(cmd_ready_out), 32'd1);
      rst_n = 1'b1;

      $display("[TB] idle pass-through");
      applyStimulus(1'b1, 12'h300, 16'hBEEF, 1'b0, 2'b11);
      #1;
      checkOutput("pt_rw", 32'(rb_rw_out), 32'd1);
      checkOutput("pt_rs", 32'(rb_rs_out), 32'h300);
      checkOutput("pt_d", 32'(rb_d_out), 32'hBEEF);
      checkOutput("pt_stall", 32'(cpu_stall_out), 32'd0);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, {4'(i), 8'h00}, (i < 8) ? 16'(16'h1000 + i) : 16'(16'hA000 + i), 1'b0, 2'b11);
      end
      idleCycle();
      checkOutput("preload_r3", 32'(bank[3]), 32'h1003);

      $display("[TB] SAVE");
      runOp(2'b00, 1'b0);
      idleCycle();
      #1;
      checkOutput("save_done_drop", 32'(done_out), 32'd0);
      for (int i = 0; i < 8; i++) checkOutput("save_hidden", 32'(bank[8 + i]), 32'(16'h1000 + i));

      $display("[TB] RESTORE");
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, {4'(i), 8'h00}, 16'h0000, 1'b0, 2'b11);
      idleCycle();
      checkOutput("wipe_r7", 32'(bank[7]), 32'h0000);
      runOp(2'b01, 1'b0);
      idleCycle();
      for (int i = 0; i < 8; i++) checkOutput("restore_user", 32'(bank[i]), 32'(16'h1000 + i));

      $display("[TB] CLEAR");
      runOp(2'b10, 1'b0);
      idleCycle();
      for (int i = 0; i < 8; i++) checkOutput("clear_user", 32'(bank[i]), 32'h0000);
      for (int i = 0; i < 8; i++) checkOutput("clear_hidden", 32'(bank[8 + i]), 32'(16'h1000 + i));

      $display("[TB] NOP with same-cycle CPU write");
      applyStimulus(1'b1, 12'h500, 16'h7777, 1'b1, 2'b11);
      #1;
      checkOutput("nop_ready", 32'(cmd_ready_out), 32'd1);
      checkOutput("nop_hs_rw", 32'(rb_rw_out), 32'd1);
      idleCycle();
      #1;
      checkOutput("nop_done", 32'(done_out), 32'd1);
      checkOutput("nop_stall", 32'(cpu_stall_out), 32'd0);
      checkOutput("nop_cpu_wr", 32'(bank[5]), 32'h7777);
      idleCycle();
      #1;
      checkOutput("nop_done_drop", 32'(done_out), 32'd0);
      checkOutput("nop_stall2", 32'(cpu_stall_out), 32'd0);

      $display("[TB] back-to-back RESTORE");
      runOp(2'b01, 1'b1);
      runBody(2'b01, 1'b0);
      idleCycle();
      #1;
      checkOutput("b2b_done_drop", 32'(done_out), 32'd0);
      for (int i = 0; i < 8; i++) checkOutput("b2b_user", 32'(bank[i]), 32'(16'h1000 + i));

      $display("[TB] reset during SAVE");
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, {4'(i), 8'h00}, 16'(16'h2000 + i), 1'b0, 2'b11);
      applyStimulus(1'b0, 12'h000, 16'h0000, 1'b1, 2'b00);
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, {4'(k), 8'h00}, 16'hDEAD, 1'b0, 2'b00);
      #1;
      checkOutput("abort_rs_idx3", 32'(rb_rs_out), 32'hB33);
      cpu_rw_in = 1'b0;
      rst_n     = 1'b0;
      #1;
      checkOutput("abort_stall", 32'(cpu_stall_out), 32'd0);
      checkOutput("abort_ready", 32'(cmd_ready_out), 32'd1);
      checkOutput("abort_rw", 32'(rb_rw_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int c = 0; c < 12; c++) begin
         idleCycle();
         #1;
         if (done_out) done_seen++;
      end
      checkOutput("abort_no_done", 32'(done_seen), 32'd0);
      checkOutput("abort_h10", 32'(bank[10]), 32'h2002);
      checkOutput("abort_h11", 32'(bank[11]), 32'h1003);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
